// File: rtl/knapsack_circuit.sv
// knapsack_circuit: switch/button driven 0/1 knapsack solver (up to 4 items) with 8-digit seven-segment readout
module knapsack_circuit #(
  parameter int DEBOUNCE = 100,
  parameter int REFRESH_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_signal_c,
  input  logic       in_signal_r,
  input  logic [3:0] sw,
  output logic [7:0] an,
  output logic [6:0] seg
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int SW_ = REFRESH_BITS + 3;
  typedef enum logic [1:0] {INPUT, SOLVE, DONE} state_t;
  state_t state;
  logic [1:0] raw, press;
  logic c_p, r_p;
  logic [3:0] stage, n_raw, cap, slot, mask, best_m;
  logic [3:0] wt [4];
  logic [3:0] pr [4];
  logic [5:0] wsum, psum, best_p, best_w;
  logic [2:0] n, dig;
  logic [3:0] nib;
  logic blank, done, last_mask;
  logic [SW_-1:0] scan;
  assign raw = {in_signal_r, in_signal_c};
  for (genvar g = 0; g < 2; g++) begin : db
    logic lvl, pulse;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        lvl <= 1'b0;
        cnt <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (raw[g] == lvl) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE - 1)) begin
          cnt <= '0;
          lvl <= raw[g];
          pulse <= raw[g];
        end else cnt <= cnt + 1'b1;
      end
    end
    assign press[g] = pulse;
  end
  assign c_p = press[0];
  assign r_p = press[1] & ~press[0];
  assign n = n_raw > 4'd4 ? 3'd4 : n_raw[2:0];
  assign last_mask = mask == 4'((5'd1 << n) - 5'd1);
  always_comb begin
    wsum = '0;
    psum = '0;
    for (int i = 0; i < 4; i++) begin
      wsum = wsum + (mask[i] ? {2'b0, wt[i]} : 6'd0);
      psum = psum + (mask[i] ? {2'b0, pr[i]} : 6'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INPUT;
      slot <= '0;
      stage <= '0;
      n_raw <= '0;
      cap <= '0;
      mask <= '0;
      best_p <= '0;
      best_w <= '0;
      best_m <= '0;
      for (int i = 0; i < 4; i++) begin
        wt[i] <= '0;
        pr[i] <= '0;
      end
    end else if (state == INPUT) begin
      if (c_p) stage <= sw;
      else if (r_p) begin
        if (slot == 4'd0) n_raw <= stage;
        else if (slot == 4'd1) cap <= stage;
        else if (slot < 4'(n) + 4'd2) wt[2'(slot - 4'd2)] <= stage;
        else pr[2'(slot - 4'd2 - 4'(n))] <= stage;
        slot <= slot + 1'b1;
        if (slot == {n, 1'b1}) state <= SOLVE;
      end
    end else if (state == SOLVE) begin
      // strict compare keeps the lowest mask on ties
      if (wsum <= {2'b0, cap} && psum > best_p) begin
        best_p <= psum;
        best_w <= wsum;
        best_m <= mask;
      end
      mask <= mask + 1'b1;
      if (last_mask) state <= DONE;
    end
  end
  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction
  assign dig = scan[SW_-1 -: 3];
  assign done = state == DONE;
  always_comb begin
    nib = done ? (dig == 3'd0 ? best_p[3:0] :
                  dig == 3'd1 ? {2'b0, best_p[5:4]} :
                  dig == 3'd2 ? best_w[3:0] :
                  dig == 3'd3 ? {2'b0, best_w[5:4]} : best_m)
               : (dig == 3'd7 ? slot : stage);
    blank = done ? dig > 3'd4 : (dig != 3'd0 && dig != 3'd7);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= '0;
      an <= 8'hFE;
      seg <= 7'h40;
    end else begin
      scan <= scan + 1'b1;
      an <= ~(8'd1 << dig);
      seg <= blank ? 7'h7F : font(nib);
    end
  end
endmodule

// File: tb/tb_knapsack_circuit.sv
// tb_knapsack_circuit: directed entry sequences, display expectations checked by a scoreboard monitor
module tb_knapsack_circuit;
  localparam int DB = 100;
  logic clk = 1'b0, rst = 1'b1, in_signal_c = 1'b0, in_signal_r = 1'b0;
  logic [3:0] sw = 4'd0;
  logic [7:0] an;
  logic [6:0] seg;
  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    string name;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit busy = 1'b0;
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  knapsack_circuit #(.DEBOUNCE(DB), .REFRESH_BITS(4)) circuit (
    .clk(clk), .rst(rst), .in_signal_c(in_signal_c), .in_signal_r(in_signal_r),
    .sw(sw), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  initial begin : monitor
    exp_t e;
    int t;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        busy = 1'b1;
        t = 0;
        while (an !== e.an && t < 400) begin
          @(negedge clk);
          t++;
        end
        checks++;
        if (t >= 400) begin
          errors++;
          $display("FAIL %s: anode %h never appeared (last %h)", e.name, e.an, an);
        end else if (seg !== e.seg) begin
          errors++;
          $display("FAIL %s: seg %h expected %h", e.name, seg, e.seg);
        end
        busy = 1'b0;
      end
    end
  end
  task automatic expect_dig(input int d, input logic [6:0] s, input string nm);
    exp_t e;
    e.an = ~(8'd1 << d);
    e.seg = s;
    e.name = nm;
    q.push_back(e);
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() > 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unresolved", q.size());
    end
  endtask
  task automatic hold(input bit r);
    if (r) in_signal_r = 1'b1;
    else in_signal_c = 1'b1;
    repeat (500) @(negedge clk);
    in_signal_c = 1'b0;
    in_signal_r = 1'b0;
    repeat (150) @(negedge clk);
  endtask
  task automatic word(input logic [3:0] v, input int slot);
    sw = v;
    hold(1'b0);
    expect_dig(0, font[v], $sformatf("stage_%0d", slot));
    expect_dig(7, font[slot], $sformatf("slot_%0d", slot));
    drain();
    hold(1'b1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic expect_done(input logic [6:0] d0, d1, d2, d3, d4, input string nm);
    expect_dig(0, d0, {nm, "_p0"});
    expect_dig(1, d1, {nm, "_p1"});
    expect_dig(2, d2, {nm, "_w0"});
    expect_dig(3, d3, {nm, "_w1"});
    expect_dig(4, d4, {nm, "_mask"});
    expect_dig(5, 7'h7F, {nm, "_blank5"});
    expect_dig(7, 7'h7F, {nm, "_blank7"});
    drain();
  endtask
  initial begin
    do_reset();
    checks++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      errors++;
      $display("FAIL reset_out: an=%h seg=%h expected FE 40", an, seg);
    end
    for (int k = 0; k < 8; k++)
      expect_dig(k, (k == 0 || k == 7) ? 7'h40 : 7'h7F, $sformatf("scan_%0d", k));
    expect_dig(0, 7'h40, "scan_wrap");
    drain();
    // short glitches never reach the filter threshold
    sw = 4'd3;
    for (int i = 0; i < 5; i++) begin
      in_signal_c = 1'b1;
      repeat (20) @(negedge clk);
      in_signal_c = 1'b0;
      repeat (20) @(negedge clk);
    end
    in_signal_c = 1'b1;
    repeat (DB - 1) @(negedge clk);
    in_signal_c = 1'b0;
    repeat (20) @(negedge clk);
    expect_dig(0, 7'h40, "bounce_none");
    drain();
    sw = 4'd5;
    hold(1'b0);
    expect_dig(0, 7'h12, "bounce_capture");
    expect_dig(7, 7'h40, "bounce_slot");
    drain();
    // N=12 clamps to 4 items; best subset {0,2}
    do_reset();
    word(4'd12, 0); word(4'd10, 1);
    word(4'd6, 2); word(4'd4, 3); word(4'd4, 4); word(4'd2, 5);
    word(4'd15, 6); word(4'd4, 7); word(4'd6, 8); word(4'd1, 9);
    expect_done(7'h12, 7'h79, 7'h08, 7'h40, 7'h12, "full");
    do_reset();
    word(4'd1, 0); word(4'd3, 1); word(4'd5, 2); word(4'd9, 3);
    expect_done(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, "infeasible");
    do_reset();
    word(4'd2, 0); word(4'd4, 1); word(4'd4, 2); word(4'd4, 3); word(4'd7, 4); word(4'd7, 5);
    expect_done(7'h78, 7'h40, 7'h19, 7'h40, 7'h79, "tie");
    // reset lands a few cycles into the 16-mask search
    do_reset();
    word(4'd4, 0); word(4'd15, 1);
    word(4'd1, 2); word(4'd1, 3); word(4'd1, 4); word(4'd1, 5);
    word(4'd1, 6); word(4'd2, 7); word(4'd3, 8);
    sw = 4'd4;
    hold(1'b0);
    in_signal_r = 1'b1;
    repeat (DB + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_signal_r = 1'b0;
    expect_dig(0, 7'h40, "rst_solve_stage");
    expect_dig(1, 7'h7F, "rst_solve_blank");
    expect_dig(7, 7'h40, "rst_solve_slot");
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
